// File: rtl/nonce_result_collector_pkg.sv
// Shared definitions for the nonce result collector.
// Contents:
//   NONCE_BITS  - width of a full hash nonce
//   nonce_t     - full nonce type
//   prefix_bits - width of the static per-core nonce prefix, given the
//                 width of the per-core low nonce counter
package collector_pkg;

   localparam int NONCE_BITS = 32;

   typedef logic [NONCE_BITS-1:0] nonce_t;

   function automatic int prefix_bits(input int countbits);
      return NONCE_BITS - countbits;
   endfunction

endpackage

// File: rtl/nonce_result_collector_fifo.sv
// result_fifo: small synchronous FIFO that buffers winning nonces.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   push, din    - write din at the tail
//   pop          - remove the head; ignored when empty
//   flush        - discard all entries; takes priority over pop, and a push in
//                  the same cycle is applied after the flush
//   full, empty  - occupancy flags
//   head         - entry at the head; meaningful only while !empty
// A push into a full FIFO is accepted only if a pop frees a slot in the same
// cycle; otherwise it is silently ignored, and the caller accounts for it.
module result_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;
   logic             do_pop;
   logic             do_push;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (flush | ~full | do_pop);

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         if (do_push) begin
            mem[0] <= din;
            wr_ptr <= AW'(1);
            count  <= (AW+1)'(1);
         end else begin
            wr_ptr <= '0;
            count  <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/nonce_result_collector.sv
// nonce_result_collector: reconstructs the nonce of each hash result coming
// out of the last lattice stage, buffers winning nonces and hands them to
// the host-side result arbiter.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   valid_i         - one hash result this cycle
//   newblock_i      - with valid_i: this result is nonce 0 of a new block
//   success_i       - with valid_i: hash met difficulty
//   nonce_prefix_i  - static high nonce bits of this core
//   res_valid_o     - head of the result buffer holds a winning nonce
//   res_ready_i     - downstream accepts the head this cycle
//   res_nonce_o     - winning nonce {prefix, count}
//   exhausted_o     - counter wrapped since last new block
//   overflow_o      - sticky: a success was dropped since last new block
//   drop_count_o    - saturating count of dropped successes
// Result handshake: a nonce transfers on every rising edge where res_valid_o
// and res_ready_i are both high; while res_valid_o is high and res_ready_i is
// low, res_nonce_o holds steady; res_valid_o never depends on res_ready_i.
module nonce_result_collector
   import collector_pkg::*;
#(
   parameter int COUNTBITS  = 6,
   parameter int FIFO_DEPTH = 4,
   parameter int DROPBITS   = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 valid_i,
   input  logic                                 newblock_i,
   input  logic                                 success_i,
   input  logic [prefix_bits(COUNTBITS)-1:0]    nonce_prefix_i,
   output logic                                 res_valid_o,
   input  logic                                 res_ready_i,
   output nonce_t                               res_nonce_o,
   output logic                                 exhausted_o,
   output logic                                 overflow_o,
   output logic [DROPBITS-1:0]                  drop_count_o
);

   logic [COUNTBITS-1:0] count_q;
   logic [COUNTBITS-1:0] cur_nonce;
   logic                 new_block;
   logic                 push;
   logic                 pop_fire;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 drop;
   nonce_t               fifo_head;

   assign new_block = valid_i & newblock_i;
   assign push      = valid_i & success_i;
   assign pop_fire  = res_valid_o & res_ready_i;

   // A new-block result is always nonce 0, regardless of the running count.
   assign cur_nonce = new_block ? '0 : count_q;

   // A push into a full buffer survives only if the head leaves this cycle.
   // A new block empties the buffer first, so it can never drop.
   assign drop = push & ~new_block & fifo_full & ~pop_fire;

   result_fifo #(
      .WIDTH (NONCE_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (res_ready_i),
      .flush (new_block),
      .din   ({nonce_prefix_i, cur_nonce}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign res_valid_o = ~fifo_empty;
   assign res_nonce_o = fifo_head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q      <= '0;
         exhausted_o  <= 1'b0;
         overflow_o   <= 1'b0;
         drop_count_o <= '0;
      end else begin
         if (valid_i) begin
            count_q <= cur_nonce + COUNTBITS'(1);
         end

         // The last nonce of the space sets exhaustion; the counter keeps
         // wrapping, so the core is now re-hashing nonces already tried.
         if (new_block) begin
            exhausted_o <= 1'b0;
         end else if (valid_i && (&cur_nonce)) begin
            exhausted_o <= 1'b1;
         end

         if (new_block) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
         end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_count_o != '1) begin
               drop_count_o <= drop_count_o + DROPBITS'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_nonce_result_collector.sv
// Directed bench for nonce_result_collector (COUNTBITS=6, FIFO_DEPTH=4,
// DROPBITS=8). A table of per-cycle records drives the main sequences;
// exhaustion, drop saturation and async reset are hand-written sequences.
module tb_nonce_result_collector;

   localparam int CB = 6;
   localparam int DB = 8;
   localparam logic [31:0] BASE = 32'h02A5_0000;
   localparam logic [25:0] P    = 26'(BASE >> 6);

   typedef struct {
      logic          v;
      logic          nb;
      logic          s;
      logic          r;
      logic          ev;
      logic [CB-1:0] en;
      logic          eexh;
      logic          eovf;
      logic [DB-1:0] edrop;
   } vec_t;

   logic          clk;
   logic          rst;
   logic          valid_i;
   logic          newblock_i;
   logic          success_i;
   logic [25:0]   nonce_prefix_i;
   logic          res_valid_o;
   logic          res_ready_i;
   logic [31:0]   res_nonce_o;
   logic          exhausted_o;
   logic          overflow_o;
   logic [DB-1:0] drop_count_o;

   int   total;
   int   bad;
   vec_t vecs[$];

   nonce_result_collector #(
      .COUNTBITS  (CB),
      .FIFO_DEPTH (4),
      .DROPBITS   (DB)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_i        (valid_i),
      .newblock_i     (newblock_i),
      .success_i      (success_i),
      .nonce_prefix_i (nonce_prefix_i),
      .res_valid_o    (res_valid_o),
      .res_ready_i    (res_ready_i),
      .res_nonce_o    (res_nonce_o),
      .exhausted_o    (exhausted_o),
      .overflow_o     (overflow_o),
      .drop_count_o   (drop_count_o)
   );

   // clock block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] nn(input logic [CB-1:0] n);
      return {P, n};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // driver: apply inputs, let one rising edge pass, settle 1 time unit
   task automatic step(input logic v, input logic nb, input logic s, input logic r);
      valid_i     = v;
      newblock_i  = nb;
      success_i   = s;
      res_ready_i = r;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic v, input logic nb, input logic s, input logic r,
                      input logic ev, input logic [CB-1:0] en, input logic eexh,
                      input logic eovf, input logic [DB-1:0] edrop);
      vec_t t;
      t.v = v; t.nb = nb; t.s = s; t.r = r;
      t.ev = ev; t.en = en; t.eexh = eexh; t.eovf = eovf; t.edrop = edrop;
      vecs.push_back(t);
   endtask

   task automatic check_all(input string tag, input logic ev, input logic [CB-1:0] en,
                            input logic eexh, input logic eovf, input logic [DB-1:0] edrop);
      chk({tag, ".valid"}, 32'(res_valid_o), 32'(ev));
      if (ev) chk({tag, ".nonce"}, res_nonce_o, nn(en));
      chk({tag, ".exh"}, 32'(exhausted_o), 32'(eexh));
      chk({tag, ".ovf"}, 32'(overflow_o), 32'(eovf));
      chk({tag, ".drop"}, 32'(drop_count_o), 32'(edrop));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst            = 1'b1;
      valid_i        = 1'b0;
      newblock_i     = 1'b0;
      success_i      = 1'b0;
      res_ready_i    = 1'b0;
      nonce_prefix_i = P;

      // reset state
      #11;
      chk("reset.valid", 32'(res_valid_o), 32'd0);
      chk("reset.nonce", res_nonce_o, 32'd0);
      chk("reset.exh", 32'(exhausted_o), 32'd0);
      chk("reset.ovf", 32'(overflow_o), 32'd0);
      chk("reset.drop", 32'(drop_count_o), 32'd0);
      #1 rst = 1'b0;

      // Seq A: newblock, success on 5th valid with gaps -> nonce 4
      //   v  nb s  r  ev en eexh eovf drop
      add(1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 1, 0, 1, 4, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0);
      // Seq B: six consecutive successes, no ready -> 0..3 kept, 2 drops
      add(1, 1, 1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1, 0, 1, 0, 0, 1, 1);
      add(1, 0, 1, 0, 1, 0, 0, 1, 2);
      add(0, 0, 0, 1, 1, 1, 0, 1, 2);
      add(0, 0, 0, 1, 1, 2, 0, 1, 2);
      add(0, 0, 0, 1, 1, 3, 0, 1, 2);
      add(0, 0, 0, 1, 0, 0, 0, 1, 2);
      // Seq C: full buffer, success with simultaneous pop -> no drop
      add(1, 1, 1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1, 1, 1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 1, 0, 0, 0);
      add(0, 0, 0, 1, 1, 2, 0, 0, 0);
      add(0, 0, 0, 1, 1, 3, 0, 0, 0);
      add(0, 0, 0, 1, 1, 4, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0);
      // Seq D: three entries held, newblock+success+pop in one cycle
      add(1, 1, 1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1, 0, 1, 0, 0, 1, 1);
      add(0, 0, 0, 1, 1, 1, 0, 1, 1);
      add(1, 1, 1, 1, 1, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].v, vecs[i].nb, vecs[i].s, vecs[i].r);
         check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].en,
                   vecs[i].eexh, vecs[i].eovf, vecs[i].edrop);
      end

      // Exhaustion: 64 valids after newblock, then a 65th wraps to nonce 0
      step(1, 1, 0, 0);
      for (int i = 1; i < 63; i++) step(1, 0, 0, 0);
      chk("exh.before", 32'(exhausted_o), 32'd0);
      step(1, 0, 0, 0);
      chk("exh.set", 32'(exhausted_o), 32'd1);
      step(1, 0, 1, 0);
      chk("exh.wrap_valid", 32'(res_valid_o), 32'd1);
      chk("exh.wrap_nonce", res_nonce_o, nn(6'd0));
      chk("exh.held", 32'(exhausted_o), 32'd1);
      step(0, 0, 0, 1);
      step(1, 1, 0, 0);
      chk("exh.cleared", 32'(exhausted_o), 32'd0);

      // Drop counter saturation: fill, then 256 more successes unaccepted
      step(1, 1, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
      for (int i = 0; i < 254; i++) step(1, 0, 1, 0);
      chk("sat.254", 32'(drop_count_o), 32'd254);
      step(1, 0, 1, 0);
      step(1, 0, 1, 0);
      chk("sat.max", 32'(drop_count_o), 32'd255);
      chk("sat.ovf", 32'(overflow_o), 32'd1);
      chk("sat.head", res_nonce_o, nn(6'd0));
      step(1, 1, 0, 1);
      chk("sat.flush_valid", 32'(res_valid_o), 32'd0);
      chk("sat.flush_drop", 32'(drop_count_o), 32'd0);

      // Async reset with a pending result, then count restarts at 0
      step(1, 0, 1, 0);
      chk("rst.pre_valid", 32'(res_valid_o), 32'd1);
      valid_i   = 1'b0;
      success_i = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("rst.async_valid", 32'(res_valid_o), 32'd0);
      #2 rst = 1'b0;
      step(1, 0, 1, 0);
      chk("rst.first_valid", 32'(res_valid_o), 32'd1);
      chk("rst.first_nonce", res_nonce_o, nn(6'd0));
      step(0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nonce_result_collector.md
Name: nonce_result_collector

Overview:
Sits directly downstream of the last-stage lattice core. Consumes its per-hash valid/newblock/success stream plus the core's fixed nonce prefix, and reconstructs the 32-bit nonce of each hash by counting valid results since the last new-block marker. Buffers winning nonces in a small FIFO and hands them to the host-side result arbiter over a valid/ready handshake. Also flags nonce-space exhaustion and dropped results.

Parameters:
COUNTBITS, 6, width of the per-core nonce counter (low nonce bits)
FIFO_DEPTH, 4, winning-nonce buffer entries (power of 2, ≥2)
DROPBITS, 8, width of the saturating dropped-result counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
valid_i  input  1  one hash result presented this cycle
newblock_i  input  1  qualified by valid_i: this result is nonce 0 of a new block
success_i  input  1  qualified by valid_i: hash met difficulty
nonce_prefix_i  input  32-COUNTBITS  core index / high nonce bits (static per core)
res_valid_o  output  1  FIFO head holds a winning nonce
res_ready_i  input  1  downstream accepts head this cycle
res_nonce_o  output  32  winning nonce = {nonce_prefix_i, count}
exhausted_o  output  1  counter wrapped; core is re-hashing old nonces
overflow_o  output  1  sticky: at least one success dropped since last new block
drop_count_o  output  DROPBITS  saturating count of dropped successes since last new block

Behaviour:
- Reset (async assert, sync release on clk): counter=0, FIFO empty, res_valid_o=0, res_nonce_o=0, exhausted_o=0, overflow_o=0, drop_count_o=0.
- Nonce of current result: if valid_i&newblock_i -> 0; else if valid_i -> count register. Count register after a valid_i cycle = (current nonce + 1) mod 2^COUNTBITS. No valid_i -> count holds. newblock_i/success_i ignored when valid_i=0.
- Push: valid_i&success_i writes {nonce_prefix_i, current nonce} into FIFO tail. res_valid_o rises next cycle (latency 1) when FIFO was empty.
- Pop: res_valid_o&res_ready_i removes head; next entry (if any) shown next cycle. res_nonce_o stable while res_valid_o&!res_ready_i.
- Full FIFO: push with simultaneous pop accepted. Push without pop dropped: overflow_o<=1, drop_count_o increments, saturating at all-ones.
- New block (valid_i&newblock_i): FIFO flushed (stale-block results useless); an entry popped by handshake that same cycle counts as delivered; same-cycle success (nonce 0) written after flush -> FIFO holds exactly that entry. exhausted_o, overflow_o, drop_count_o cleared in same edge (a same-cycle drop is impossible since FIFO is empty post-flush).
- Exhaustion: valid result with current nonce = 2^COUNTBITS-1 and no newblock -> exhausted_o<=1, held until next new block. Counter wraps to 0 and keeps counting; successes still pushed.
- rst mid-operation: all state to reset values immediately; in-flight entries lost.

Decomposition:
- Package collector_pkg: NONCE_BITS=32 constant, nonce_t typedef, prefix width function of COUNTBITS.
- Sub-module result_fifo: synchronous FIFO, parameters WIDTH/DEPTH, ports push/pop/flush/full/empty/head; flush has priority over pop, push applied after flush. Collector owns counter, exhaustion, drop logic.

Test Plan:
- COUNTBITS=6, prefix=0x2A5_0000>>6 style value P; newblock at result 0, success on 5th valid (gaps between valids) -> res_nonce_o={P,6'd4}, res_valid_o one cycle after push.
- Successes on 6 consecutive valids, res_ready_i=0 -> FIFO holds nonces 0..3, overflow_o=1, drop_count_o=2; then ready=1 -> 4 pops in order 0,1,2,3.
- FIFO full, success with res_ready_i=1 same cycle -> no drop, head advances, occupancy stays 4.
- 64 valids after newblock, 65th valid without newblock -> exhausted_o=1 from cycle after 64th; 65th result's nonce = 0; newblock clears it.
- FIFO holding 3 entries, newblock+success+pop same cycle -> popped entry delivered, FIFO holds only {P,0}, flags cleared.
- rst asserted asynchronously with res_valid_o=1 -> res_valid_o=0 before next edge; post-release first valid without newblock yields nonce 0.
